// File: rtl/value_watch_trigger.sv
// value_watch_trigger: masked compare breakpoint that halts after a programmable number of hits
module value_watch_trigger #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] CMP,
  input  logic [WIDTH-1:0] MASK,
  input  logic [1:0]       MODE,
  input  logic             EDGE,
  input  logic [CNT_W-1:0] LIMIT,
  input  logic             ARM,
  input  logic             ACK,
  output logic             HALT,
  output logic [CNT_W-1:0] HITS,
  output logic [WIDTH-1:0] CAPT,
  output logic [1:0]       STATE
);
  localparam logic [1:0] IDLE = 2'b00, ARMED = 2'b01, TRIG = 2'b10;
  logic [1:0] st, st_n;
  logic [WIDTH-1:0] a, b, capt;
  logic [CNT_W-1:0] hits, eff_lim;
  logic [CNT_W:0] hits_inc;
  logic match, match_q, arm_q, arm_rise, hit, fire;
  always_comb begin
    a = D & MASK;
    b = CMP & MASK;
    match = !$isunknown(a) && (MODE == 2'b00 ? a == b : MODE == 2'b01 ? a != b : MODE == 2'b10 ? a > b : a < b);
    arm_rise = ARM && !arm_q;
    hit = match && (!EDGE || !match_q);
    eff_lim = (LIMIT == '0) ? CNT_W'(1) : LIMIT;
    hits_inc = {1'b0, hits} + (CNT_W + 1)'(1);
    fire = hit && (hits_inc >= {1'b0, eff_lim});
  end
  always_ff @(posedge CK or negedge CLR)
    if (!CLR) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = arm_rise ? ARMED : IDLE;
      ARMED:   st_n = !ARM ? IDLE : fire ? TRIG : ARMED;
      TRIG:    st_n = ACK ? IDLE : TRIG;
      default: st_n = IDLE;
    endcase
  end
  // A trigger after LIMIT was lowered below the count clamps HITS to the limit
  always_ff @(posedge CK or negedge CLR)
    if (!CLR) begin
      match_q <= 1'b0;
      arm_q <= 1'b0;
      hits <= '0;
      capt <= '0;
    end else begin
      match_q <= match;
      arm_q <= ARM;
      if (st == IDLE && arm_rise) hits <= '0;
      else if (st == ARMED && ARM && hit) begin
        hits <= fire ? eff_lim : hits_inc[CNT_W-1:0];
        if (fire) capt <= D;
      end
    end
  always_comb begin
    HALT = st == TRIG;
    STATE = st;
    HITS = hits;
    CAPT = capt;
  end
endmodule

// File: tb/tb_value_watch_trigger.sv
// tb_value_watch_trigger: directed checks of arming, counting, compare modes, ack and reset
module tb_value_watch_trigger;
  logic CK, CLR, EDGE, ARM, ACK, HALT;
  logic [7:0] D, CMP, MASK, CAPT;
  logic [1:0] MODE, STATE;
  logic [3:0] LIMIT, HITS;
  int checks = 0, errors = 0;

  value_watch_trigger #(.WIDTH(8), .CNT_W(4)) dut (
    .CK(CK), .CLR(CLR), .D(D), .CMP(CMP), .MASK(MASK), .MODE(MODE), .EDGE(EDGE),
    .LIMIT(LIMIT), .ARM(ARM), .ACK(ACK), .HALT(HALT), .HITS(HITS), .CAPT(CAPT), .STATE(STATE)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    CLR = 1'b0; D = 8'h00; CMP = 8'h42; MASK = 8'hFF; MODE = 2'b00;
    EDGE = 1'b0; LIMIT = 4'd1; ARM = 1'b0; ACK = 1'b0;
    #12;
    chk("rst_state", STATE, 2'b00);
    chk("rst_hits", HITS, 4'd0);
    chk("rst_capt", CAPT, 8'h00);
    chk("rst_halt", HALT, 1'b0);
    CLR = 1'b1;
    // 1: EQ sweep, trigger exactly when 42 is sampled
    ARM = 1'b1;
    tick();
    chk("t1_armed", STATE, 2'b01);
    for (int k = 0; k < 12; k++) begin
      D = 8'(6 * k);
      tick();
      chk("t1_halt", HALT, k == 11);
    end
    chk("t1_capt", CAPT, 8'h42);
    chk("t1_hits", HITS, 4'd1);
    chk("t1_state", STATE, 2'b10);
    ACK = 1'b1; tick(); ACK = 1'b0;
    ARM = 1'b0; tick();
    // 2: LIMIT=3 with level match, then ACK with ARM held high
    LIMIT = 4'd3; D = 8'h42; ARM = 1'b1;
    tick();
    chk("t2_arm_hits", HITS, 4'd0);
    tick(); chk("t2_h1", HITS, 4'd1); chk("t2_nohalt1", HALT, 1'b0);
    tick(); chk("t2_h2", HITS, 4'd2); chk("t2_nohalt2", HALT, 1'b0);
    tick(); chk("t2_h3", HITS, 4'd3); chk("t2_halt", HALT, 1'b1);
    tick(); chk("t2_frozen_hits", HITS, 4'd3); chk("t2_hold_trig", STATE, 2'b10);
    ACK = 1'b1; tick(); ACK = 1'b0;
    chk("t2_ack_state", STATE, 2'b00);
    chk("t2_ack_halt", HALT, 1'b0);
    tick(); tick();
    chk("t2_no_rearm", STATE, 2'b00);
    ARM = 1'b0; tick();
    ARM = 1'b1; tick();
    chk("t2_rearm", STATE, 2'b01);
    chk("t2_rearm_hits", HITS, 4'd0);
    ARM = 1'b0; tick();
    // 3: EDGE mode ignores a match already present when arming
    EDGE = 1'b1; LIMIT = 4'd1; ARM = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_hits", HITS, 4'd0);
    end
    chk("t3_hold_state", STATE, 2'b01);
    D = 8'h00; tick();
    chk("t3_drop_hits", HITS, 4'd0);
    D = 8'h42; tick();
    chk("t3_hits", HITS, 4'd1);
    chk("t3_halt", HALT, 1'b1);
    ACK = 1'b1; tick(); ACK = 1'b0;
    ARM = 1'b0; tick();
    EDGE = 1'b0;
    // 4: masked compare on low nibble
    MASK = 8'h0F; CMP = 8'h02; LIMIT = 4'd15; D = 8'h00; ARM = 1'b1;
    tick();
    D = 8'h12; tick(); chk("t4_12", HITS, 4'd1);
    D = 8'h13; tick(); chk("t4_13", HITS, 4'd1);
    ACK = 1'b1;
    D = 8'hF2; tick(); chk("t4_F2", HITS, 4'd2);
    ACK = 1'b0;
    D = 8'b0001_011x; tick(); chk("t4_x", HITS, 4'd2);
    chk("t4_state", STATE, 2'b01);
    ARM = 1'b0; tick();
    chk("t4_disarm_hits", HITS, 4'd2);
    // 5: unsigned GT and LT
    MASK = 8'hFF; MODE = 2'b10; CMP = 8'h80; LIMIT = 4'd1; D = 8'h80; ARM = 1'b1;
    tick();
    tick(); chk("t5_gt80_hits", HITS, 4'd0); chk("t5_gt80_state", STATE, 2'b01);
    D = 8'h81; tick();
    chk("t5_gt81_halt", HALT, 1'b1);
    chk("t5_gt81_capt", CAPT, 8'h81);
    ACK = 1'b1; tick(); ACK = 1'b0;
    ARM = 1'b0; tick();
    MODE = 2'b11; D = 8'h7F; ARM = 1'b1;
    tick(); chk("t5_lt_arm", HALT, 1'b0);
    tick();
    chk("t5_lt_halt", HALT, 1'b1);
    chk("t5_lt_capt", CAPT, 8'h7F);
    ACK = 1'b1; tick(); ACK = 1'b0;
    ARM = 1'b0; tick();
    // 6: async reset mid-count, then disarm beating a hit
    MODE = 2'b00; CMP = 8'h42; D = 8'h42; LIMIT = 4'd5; ARM = 1'b1;
    tick();
    tick(); tick();
    chk("t6_pre_hits", HITS, 4'd2);
    #2 CLR = 1'b0;
    #1;
    chk("t6_clr_halt", HALT, 1'b0);
    chk("t6_clr_hits", HITS, 4'd0);
    chk("t6_clr_state", STATE, 2'b00);
    ARM = 1'b0;
    #1 CLR = 1'b1;
    tick();
    ARM = 1'b1; tick();
    tick(); tick();
    chk("t6_re_hits", HITS, 4'd2);
    ARM = 1'b0; tick();
    chk("t6_disarm_state", STATE, 2'b00);
    chk("t6_disarm_hits", HITS, 4'd2);
    // LIMIT=0 behaves as 1
    LIMIT = 4'd0; ARM = 1'b1;
    tick();
    tick();
    chk("lim0_halt", HALT, 1'b1);
    chk("lim0_hits", HITS, 4'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
